// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU responder on the control unit's ALU handshake.
//   clk, rst_n          clock, asynchronous active-low reset
//   alu_executing       request, sampled only while idle
//   a, b, op            operands and opcode, latched on the accept edge
//   alu_done, busy      handshake status (alu_done = !busy)
//   result, result_hi   low result / quotient, high product / remainder
//   flags               {V,N,C,Z}
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_executing,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             alu_done,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic             add_v;
  logic             sub_v;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx;
  logic [WIDTH-1:0] div_quo_nx;
  logic             last_step;
  logic             finish;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    work_hi_d   = work_hi_q;
    work_lo_d   = work_lo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    finish      = 1'b0;

    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    add_v    = (a_q[MSB] == b_q[MSB]) && (add_sum[MSB] != a_q[MSB]);
    sub_v    = (a_q[MSB] != b_q[MSB]) && (sub_diff[MSB] != a_q[MSB]);

    logic_res = '0;
    case (op_q)
      OP_AND:  logic_res = a_q & b_q;
      OP_OR:   logic_res = a_q | b_q;
      OP_XOR:  logic_res = a_q ^ b_q;
      default: logic_res = '0;
    endcase

    // Multiply: work_hi holds the partial product, work_lo the remaining
    // multiplier bits; product shifts right into work_lo as bits retire.
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], work_lo_q[WIDTH-1:1]};

    // Divide: work_hi is the partial remainder, work_lo shifts dividend bits
    // out at the top and quotient bits in at the bottom. The trial subtract
    // is two bits wider since the shifted remainder can reach 2*b-1.
    div_shift  = {work_hi_q, work_lo_q[MSB]};
    div_trial  = {1'b0, div_shift} - {2'b00, b_q};
    div_ge     = !div_trial[WIDTH+1];
    div_rem_nx = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_nx = {work_lo_q[WIDTH-2:0], div_ge};

    last_step = (cnt_q == CW'(WIDTH - 1));

    unique case (state_q)
      ST_IDLE: begin
        if (alu_executing) begin
          a_d       = a;
          b_d       = b;
          op_d      = op_e'(op);
          cnt_d     = '0;
          work_hi_d = '0;
          work_lo_d = (op_e'(op) == OP_MUL) ? b : a;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        unique case (op_q)
          OP_ADD: begin
            result_d    = add_sum[WIDTH-1:0];
            result_hi_d = '0;
            flags_d     = {add_v, add_sum[MSB], add_sum[WIDTH], add_sum[WIDTH-1:0] == '0};
            finish      = 1'b1;
          end
          OP_SUB: begin
            result_d    = sub_diff[WIDTH-1:0];
            result_hi_d = '0;
            flags_d     = {sub_v, sub_diff[MSB], sub_diff[WIDTH], sub_diff[WIDTH-1:0] == '0};
            finish      = 1'b1;
          end
          OP_CMP: begin
            flags_d = {sub_v, sub_diff[MSB], sub_diff[WIDTH], sub_diff[WIDTH-1:0] == '0};
            finish  = 1'b1;
          end
          OP_AND, OP_OR, OP_XOR: begin
            result_d    = logic_res;
            result_hi_d = '0;
            flags_d     = {1'b0, logic_res[MSB], 1'b0, logic_res == '0};
            finish      = 1'b1;
          end
          OP_MUL: begin
            work_hi_d = mul_hi_nx;
            work_lo_d = mul_lo_nx;
            if (last_step) begin
              result_d    = mul_lo_nx;
              result_hi_d = mul_hi_nx;
              flags_d     = {mul_hi_nx != '0, mul_hi_nx[MSB], 1'b0,
                             {mul_hi_nx, mul_lo_nx} == '0};
              finish      = 1'b1;
            end
          end
          OP_DIV: begin
            work_hi_d = div_rem_nx;
            work_lo_d = div_quo_nx;
            if (b_q == '0) begin
              result_d    = '1;
              result_hi_d = a_q;
              flags_d     = 4'b1100;
              finish      = 1'b1;
            end else if (last_step) begin
              result_d    = div_quo_nx;
              result_hi_d = div_rem_nx;
              flags_d     = {1'b0, div_quo_nx[MSB], 1'b0, div_quo_nx == '0};
              finish      = 1'b1;
            end
          end
        endcase
        if (finish) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (!alu_executing) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_BUSY);
    done_d = !busy_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_hi_q   <= work_hi_d;
      work_lo_q   <= work_lo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign alu_done  = done_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an
// arithmetic reference model.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int FULL = 2 ** W;
  localparam int HALF = 2 ** (W - 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alu_executing;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         alu_done;
  logic         busy;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_res   = 0;
  int exp_hi    = 0;
  int exp_flags = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_executing (alu_executing),
    .a             (a),
    .b             (b),
    .op            (op),
    .alu_done      (alu_done),
    .busy          (busy),
    .result        (result),
    .result_hi     (result_hi),
    .flags         (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= HALF) ? v - FULL : v;
  endfunction

  // Reference model: updates the expected output registers, returns latency.
  function automatic int model(input int av, input int bv, input int opv);
    int r, hi, v, n, c, z, s, p;
    r = exp_res; hi = 0; v = 0; c = 0;
    case (opv)
      0: begin s = sgn(av) + sgn(bv); r = (av + bv) % FULL; c = (av + bv >= FULL); v = (s >= HALF || s < -HALF); end
      1, 7: begin s = sgn(av) - sgn(bv); r = (av - bv + FULL) % FULL; c = (av < bv); v = (s >= HALF || s < -HALF); end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: begin p = av * bv; r = p % FULL; hi = p / FULL; v = (hi != 0); end
      default: begin
        if (bv == 0) begin r = FULL - 1; hi = av; v = 1; end
        else begin r = av / bv; hi = av % bv; end
      end
    endcase
    if (opv == 5) begin n = (hi >= HALF); z = (r == 0 && hi == 0); end
    else begin n = (r >= HALF); z = (r == 0); end
    exp_flags = (v << 3) | (n << 2) | (c << 1) | z;
    if (opv != 7) begin exp_res = r; exp_hi = hi; end
    return ((opv == 5) || (opv == 6 && bv != 0)) ? W : 1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".result"}, 16'(result), 16'(exp_res));
    check({tag, ".hi"}, 16'(result_hi), 16'(exp_hi));
    check({tag, ".flags"}, 16'(flags), 16'(exp_flags));
  endtask

  task automatic run_op(input string tag, input int av, input int bv, input int opv, input int hold);
    int lat, low;
    @(negedge clk);
    a = W'(av); b = W'(bv); op = 3'(opv); alu_executing = 1'b1;
    lat = model(av, bv, opv);
    @(posedge clk);
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= hold - 1) alu_executing = 1'b0;
      if (alu_done) break;
      check({tag, ".busy_while_low"}, 16'(busy), 16'd1);
      low++;
    end
    alu_executing = 1'b0;
    check({tag, ".low_cycles"}, 16'(low), 16'(lat));
    check_outputs(tag);
    // Outputs must hold and no further operation may start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, ".idle_done"}, 16'({alu_done, busy}), 16'b10);
    end
    check_outputs({tag, ".hold"});
  endtask

  initial begin
    int ra, rb, ro, rh;
    rst_n = 1'b0; alu_executing = 1'b0; a = '0; b = '0; op = '0;
    #12;
    check("reset.done_busy", 16'({alu_done, busy}), 16'b10);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset.done_busy", 16'({alu_done, busy}), 16'b10);
      check_outputs("post_reset");
    end

    run_op("add_f0_20", 'hF0, 'h20, 0, 2);
    run_op("sub_80_01", 'h80, 'h01, 1, 2);
    run_op("cmp_80_01", 'h80, 'h01, 7, 1);
    run_op("cmp_05_05", 'h05, 'h05, 7, 2);
    run_op("mul_ff_ff", 'hFF, 'hFF, 5, 2);
    run_op("mul_00_37", 'h00, 'h37, 5, 1);
    run_op("div_c8_0b", 'hC8, 'h0B, 6, 2);
    run_op("div_42_00", 'h42, 'h00, 6, 2);
    run_op("and_f0_3c", 'hF0, 'h3C, 2, 1);
    run_op("or_00_00", 'h00, 'h00, 3, 1);
    run_op("xor_ff_0f", 'hFF, 'h0F, 4, 3);
    run_op("add_7f_01", 'h7F, 'h01, 0, 1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    a = 8'h12; b = 8'h34; op = 3'd5; alu_executing = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_executing = 1'b0;
      check("mid_mul.busy", 16'({alu_done, busy}), 16'b01);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_res = 0; exp_hi = 0; exp_flags = 0;
    check("mid_mul_reset.done_busy", 16'({alu_done, busy}), 16'b10);
    check_outputs("mid_mul_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset.done_busy", 16'({alu_done, busy}), 16'b10);
    run_op("add_01_01", 1, 1, 0, 1);

    for (int k = 0; k < 30; k++) begin
      ra = int'($urandom_range(FULL - 1, 0));
      rb = int'($urandom_range(FULL - 1, 0));
      ro = int'($urandom_range(7, 0));
      rh = int'($urandom_range(3, 1));
      if (ro == 6 && k % 7 == 0) rb = 0;
      run_op("random", ra, rb, ro, rh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
